// File: rtl/beep_pkg.sv
// Shared types and sizing helpers for the buzzer cadence generator.
package beep_pkg;

  typedef enum logic [2:0] {SILENT, SLOW, FAST, BURST, CONT} mode_t;
  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} fsm_t;

  localparam int unsigned DEF_STATE_W    = 3;
  localparam int unsigned DEF_TONE_HALF  = 25000;
  localparam int unsigned DEF_TICK_DIV   = 5000000;
  localparam int unsigned DEF_SLOW_TICKS = 5;
  localparam int unsigned DEF_BURST_N    = 3;
  localparam int unsigned DEF_GAP_TICKS  = 10;

  // Bits needed to hold 0..lim without wrapping; never narrower than 1.
  function automatic int unsigned cnt_w(input int unsigned lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic mode_t state_to_mode(input logic [31:0] s);
    case (s)
      32'd0:   return SILENT;
      32'd1:   return SLOW;
      32'd2:   return FAST;
      32'd3:   return BURST;
      default: return CONT;
    endcase
  endfunction

endpackage

// File: rtl/beep_tone_gen.sv
// Square-wave tone source; restarts high whenever the gate opens or a clear is seen.
module beep_tone_gen
  import beep_pkg::*;
#(
  parameter int unsigned TONE_HALF = DEF_TONE_HALF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic gate,
  output logic tone_q
);

  localparam int unsigned TW = cnt_w(TONE_HALF);

  logic [TW-1:0] cnt;

  // Held preset to 1 while the gate is closed, so the first on-cycle is high.
  always_ff @(posedge clk) begin
    if (rst || clear || !gate) begin
      cnt    <= '0;
      tone_q <= 1'b1;
    end else if (cnt == TW'(TONE_HALF - 1)) begin
      cnt    <= '0;
      tone_q <= ~tone_q;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/beep_pattern_gen.sv
// Severity-to-cadence buzzer driver: cadence FSM, mute/re-arm and tone gating.
module beep_pattern_gen
  import beep_pkg::*;
#(
  parameter int unsigned STATE_W    = DEF_STATE_W,
  parameter int unsigned TONE_HALF  = DEF_TONE_HALF,
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned SLOW_TICKS = DEF_SLOW_TICKS,
  parameter int unsigned BURST_N    = DEF_BURST_N,
  parameter int unsigned GAP_TICKS  = DEF_GAP_TICKS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               beep_en,
  input  logic [STATE_W-1:0] state,
  input  logic               mute,
  output logic               beep_out,
  output logic               active
);

  localparam int unsigned PRE_W = cnt_w(TICK_DIV);
  localparam int unsigned PH_W  = cnt_w(max2(SLOW_TICKS, GAP_TICKS));
  localparam int unsigned BR_W  = cnt_w(BURST_N);

  logic [STATE_W-1:0] state_q;
  fsm_t               fsm;
  logic [PRE_W-1:0]   presc;
  logic [PH_W-1:0]    phase;
  logic [BR_W-1:0]    burst;
  logic               muted;

  logic               change, tick, gate, tone_q;
  mode_t              mode, new_mode;
  logic [PH_W-1:0]    on_last, off_last;

  assign change   = (state != state_q);
  assign mode     = state_to_mode(32'(state_q));
  assign new_mode = state_to_mode(32'(state));
  assign gate     = (fsm == ON);
  assign tick     = (fsm != IDLE) && (presc == PRE_W'(TICK_DIV - 1));

  always_comb begin
    on_last  = '0;
    off_last = '0;
    if (mode == SLOW) begin
      on_last  = PH_W'(SLOW_TICKS - 1);
      off_last = PH_W'(SLOW_TICKS - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= '0;
      fsm      <= IDLE;
      presc    <= '0;
      phase    <= '0;
      burst    <= '0;
      muted    <= 1'b0;
      beep_out <= 1'b0;
      active   <= 1'b0;
    end else begin
      state_q  <= state;
      active   <= gate & beep_en & ~muted;
      beep_out <= gate & tone_q & beep_en & ~muted;

      // Escalation re-arms and takes priority over a coincident mute pulse.
      if (change && (state > state_q))
        muted <= 1'b0;
      else if (mute && beep_en)
        muted <= 1'b1;

      if (change) begin
        presc <= '0;
        phase <= '0;
        burst <= '0;
        fsm   <= (new_mode == SILENT) ? IDLE : ON;
      end else begin
        if (fsm != IDLE)
          presc <= tick ? '0 : presc + 1'b1;
        if (tick) begin
          case (fsm)
            ON: begin
              if (mode != CONT) begin
                if (phase == on_last) begin
                  phase <= '0;
                  fsm   <= OFF;
                end else begin
                  phase <= phase + 1'b1;
                end
              end
            end
            OFF: begin
              if (phase == off_last) begin
                phase <= '0;
                if (mode == BURST && burst == BR_W'(BURST_N - 1)) begin
                  burst <= '0;
                  fsm   <= GAP;
                end else begin
                  if (mode == BURST)
                    burst <= burst + 1'b1;
                  fsm <= ON;
                end
              end else begin
                phase <= phase + 1'b1;
              end
            end
            GAP: begin
              if (phase == PH_W'(GAP_TICKS - 1)) begin
                phase <= '0;
                burst <= '0;
                fsm   <= ON;
              end else begin
                phase <= phase + 1'b1;
              end
            end
            default: fsm <= IDLE;
          endcase
        end
      end
    end
  end

  beep_tone_gen #(
    .TONE_HALF(TONE_HALF)
  ) u_tone (
    .clk   (clk),
    .rst   (rst),
    .clear (change),
    .gate  (gate),
    .tone_q(tone_q)
  );

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Bench for beep_pattern_gen: directed vector table plus randomized run against a time-based model.
module tb_beep_pattern_gen;

  localparam int TH = 2;
  localparam int TD = 10;
  localparam int ST = 5;
  localparam int BN = 3;
  localparam int GT = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       beep_en = 1'b1;
  logic [2:0] state = 3'd0;
  logic       mute = 1'b0;
  logic       beep_out, active;

  int n_checks = 0;
  int n_fail   = 0;

  beep_pattern_gen #(
    .STATE_W   (3),
    .TONE_HALF (TH),
    .TICK_DIV  (TD),
    .SLOW_TICKS(ST),
    .BURST_N   (BN),
    .GAP_TICKS (GT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .beep_en (beep_en),
    .state   (state),
    .mute    (mute),
    .beep_out(beep_out),
    .active  (active)
  );

  always #5 clk = ~clk;

  // Reference model: gate computed from elapsed cycles since the pattern (re)started.
  function automatic bit gate_of(input int s, input int t);
    int pos;
    case (s)
      0: return 1'b0;
      1: return ((t / (TD * ST)) % 2) == 0;
      2: return ((t / TD) % 2) == 0;
      3: begin
        pos = t % (2 * BN * TD + GT * TD);
        return (pos < 2 * BN * TD) && (((pos / TD) % 2) == 0);
      end
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit tone_of(input int age);
    return ((age / TH) % 2) == 0;
  endfunction

  int m_sq = 0, m_t = 0, m_age = 0;
  bit m_gate = 0, m_muted = 0, m_valid = 0, exp_active = 0, exp_beep = 0;

  always @(posedge clk) begin
    bit chg, prev_gate;
    if (rst) begin
      m_sq = 0; m_t = 0; m_age = 0; m_gate = 0; m_muted = 0;
      exp_active = 0; exp_beep = 0; m_valid = 1;
    end else begin
      exp_active = m_gate && beep_en && !m_muted;
      exp_beep   = exp_active && tone_of(m_age);
      chg = (int'(state) != m_sq);
      if (chg && int'(state) > m_sq) m_muted = 0;
      else if (mute && beep_en) m_muted = 1;
      prev_gate = m_gate;
      m_t  = chg ? 0 : m_t + 1;
      m_sq = int'(state);
      m_gate = gate_of(m_sq, m_t);
      m_age = (chg || !prev_gate) ? 0 : m_age + 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_checks++;
      if (active !== exp_active || beep_out !== exp_beep) begin
        n_fail++;
        $display("FAIL model t=%0t: active=%b beep_out=%b, required active=%b beep_out=%b",
                 $time, active, beep_out, exp_active, exp_beep);
      end
    end
  end

  typedef struct {
    bit       r;
    bit [2:0] st;
    bit       en;
    bit       mu;
    int       n;
    bit       ea;
    bit       eb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input int st, input bit en, input bit mu, input int n,
                     input bit ea, input bit eb);
    vec_t v;
    v.r = r; v.st = 3'(st); v.en = en; v.mu = mu; v.n = n; v.ea = ea; v.eb = eb;
    vecs.push_back(v);
  endtask

  // Called at a negedge: drive inputs, let n rising edges pass, return at the next negedge.
  task automatic run(input bit r, input bit [2:0] st, input bit en, input bit mu, input int n);
    rst = r; state = st; beep_en = en; mute = mu;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1 mute = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //   rst st en mu  n  active beep
    add(1, 0, 1, 0,   3, 0, 0);
    add(0, 0, 1, 0,  50, 0, 0);
    add(0, 1, 1, 0,   1, 0, 0);   // change not yet visible
    add(0, 1, 1, 0,   1, 1, 1);   // 2 clk latency
    add(0, 1, 1, 0,   1, 1, 1);
    add(0, 1, 1, 0,   1, 1, 0);
    add(0, 1, 1, 0,  47, 1, 1);   // last on-cycle of slow pulse
    add(0, 1, 1, 0,   1, 0, 0);
    add(0, 1, 1, 0,  49, 0, 0);
    add(0, 1, 1, 0,   1, 1, 1);   // second slow period
    add(0, 3, 1, 0,   2, 1, 1);   // burst restarts cadence
    add(0, 3, 1, 0,  10, 0, 0);
    add(0, 3, 1, 0,  10, 1, 1);
    add(0, 3, 1, 0,  40, 0, 0);   // gap after third beep
    add(0, 3, 1, 0, 100, 1, 1);   // burst repeats
    add(0, 3, 1, 0,   9, 1, 1);
    add(0, 4, 1, 0,   2, 1, 1);
    add(0, 4, 1, 0,   3, 1, 0);
    add(0, 4, 0, 0,   1, 0, 0);   // disable forces silence next cycle
    add(0, 4, 0, 0,   5, 0, 0);
    add(0, 4, 1, 0,   1, 1, 0);   // tone phase kept running
    add(0, 4, 1, 0,   2, 1, 1);
    add(0, 2, 1, 0,   2, 1, 1);
    add(0, 2, 1, 1,   1, 1, 1);   // mute takes effect one cycle later
    add(0, 2, 1, 0,   1, 0, 0);
    add(0, 1, 1, 0,   2, 0, 0);   // de-escalation stays muted
    add(0, 1, 1, 0,  10, 0, 0);
    add(0, 3, 1, 0,   2, 1, 1);   // escalation re-arms
    add(0, 4, 1, 0,   2, 1, 1);
    add(1, 4, 1, 0,   1, 0, 0);   // reset mid-ON
    add(0, 4, 1, 0,   1, 0, 0);
    add(0, 4, 1, 0,   1, 1, 1);
    add(0, 1, 1, 0,   2, 1, 1);
    add(0, 3, 1, 1,   2, 1, 1);   // mute coincident with escalation
    add(0, 3, 1, 0,   1, 1, 1);

    @(negedge clk);
    foreach (vecs[i]) begin
      run(vecs[i].r, vecs[i].st, vecs[i].en, vecs[i].mu, vecs[i].n);
      n_checks++;
      if (active !== vecs[i].ea || beep_out !== vecs[i].eb) begin
        n_fail++;
        $display("FAIL vec%0d: active=%b beep_out=%b, required active=%b beep_out=%b",
                 i, active, beep_out, vecs[i].ea, vecs[i].eb);
      end
    end

    for (int s = 0; s < 80; s++) begin
      bit       r  = ($urandom_range(0, 15) == 0);
      bit [2:0] st = 3'($urandom_range(0, 7));
      bit       en = ($urandom_range(0, 7) != 0);
      bit       mu = ($urandom_range(0, 3) == 0);
      int       n  = r ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 120));
      run(r, st, en, mu, n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
